// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the writeback arbiter signals: issue-stage scoreboard access,
// the two writeback request channels and the register-file write port.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Scoreboard set / lookup
  logic              set_en_i;
  logic [ADDR_W-1:0] set_addr_i;
  logic [ADDR_W-1:0] r1_addr_i;
  logic [ADDR_W-1:0] r2_addr_i;
  logic              r1_busy_o;
  logic              r2_busy_o;

  // Requester 0 (ALU)
  logic              req0_valid_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_data_i;
  logic              req0_ready_o;

  // Requester 1 (load unit)
  logic              req1_valid_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_data_i;
  logic              req1_ready_o;

  // Register-file write port and status
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;
  logic              idle_o;

  // Arbiter side
  modport slave (
    input  set_en_i, set_addr_i, r1_addr_i, r2_addr_i,
    input  req0_valid_i, req0_addr_i, req0_data_i,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    output r1_busy_o, r2_busy_o, req0_ready_o, req1_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, idle_o
  );

  // Requester / issue-stage side
  modport master (
    output set_en_i, set_addr_i, r1_addr_i, r2_addr_i,
    output req0_valid_i, req0_addr_i, req0_data_i,
    output req1_valid_i, req1_addr_i, req1_data_i,
    input  r1_busy_o, r2_busy_o, req0_ready_o, req1_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, idle_o
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// Round-robin between ALU (req0) and load unit (req1), registered write
// stage with one cycle of latency, and a pending-write scoreboard that the
// issue stage queries to stall on registers still awaiting writeback.
// Writes to x0 are accepted but never reach the register file.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rf_wb_arbiter_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic [NREG-1:0]   set_vec_s;
  logic [NREG-1:0]   clr_vec_s;
  logic              rr_r;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              xfer_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [DATA_W-1:0] rf_wdata_r;

  // Grant: sole requester wins, rr picks on contention, nothing during reset
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!rst_ni) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (bus.req0_valid_i && bus.req1_valid_i) begin
      gnt0_s = (rr_r == 1'b0);
      gnt1_s = (rr_r == 1'b1);
    end else begin
      gnt0_s = bus.req0_valid_i;
      gnt1_s = bus.req1_valid_i;
    end
  end

  // Mux the accepted request onto the write stage input
  always_comb begin
    sel_addr_s = bus.req0_addr_i;
    sel_data_s = bus.req0_data_i;
    if (gnt1_s) begin
      sel_addr_s = bus.req1_addr_i;
      sel_data_s = bus.req1_data_i;
    end else begin
      sel_addr_s = bus.req0_addr_i;
      sel_data_s = bus.req0_data_i;
    end
  end

  assign xfer_s = gnt0_s | gnt1_s;

  // Scoreboard update: x0 is never marked; a set beats a same-edge clear
  assign set_vec_s  = (NREG'(bus.set_en_i) << bus.set_addr_i) & ~NREG'(1'b1);
  assign clr_vec_s  = NREG'(rf_we_r) << rf_waddr_r;
  assign busy_nxt_s = set_vec_s | (busy_r & ~clr_vec_s);

  // State: scoreboard, rr pointer and the registered write stage
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_r     <= {NREG{1'b0}};
      rr_r       <= 1'b0;
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_wdata_r <= {DATA_W{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      if (xfer_s) begin
        // Pointer moves to whichever requester lost this transfer
        rr_r    <= gnt0_s;
        rf_we_r <= (sel_addr_s != {ADDR_W{1'b0}});
        if (sel_addr_s != {ADDR_W{1'b0}}) begin
          rf_waddr_r <= sel_addr_s;
          rf_wdata_r <= sel_data_s;
        end
      end else begin
        rf_we_r <= 1'b0;
      end
    end
  end

  assign bus.req0_ready_o = gnt0_s;
  assign bus.req1_ready_o = gnt1_s;
  assign bus.r1_busy_o    = busy_r[bus.r1_addr_i];
  assign bus.r2_busy_o    = busy_r[bus.r2_addr_i];
  assign bus.rf_we_o      = rf_we_r;
  assign bus.rf_waddr_o   = rf_waddr_r;
  assign bus.rf_wdata_o   = rf_wdata_r;
  assign bus.idle_o       = (busy_r == {NREG{1'b0}}) && !rf_we_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a reference arbitration model
// predicts grants and pushes expected writes into a queue; a monitor pops
// and compares them whenever the write port fires.
module tb_rf_wb_arbiter;
  logic clk_i;
  logic rst_ni;

  rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  int          push_cnt  = 0;
  int          pulse_cnt = 0;
  logic [36:0] exp_q[$];
  logic        rr_m;
  logic        g0_m;
  logic        g1_m;
  logic [31:0] rf_mem [0:31];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write-port pulse must match the oldest expected write
  always @(negedge clk_i) begin
    if (bus.rf_we_o === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_we", {31'd0, bus.rf_we_o}, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check_eq("wb_addr", {27'd0, bus.rf_waddr_o}, {27'd0, e[36:32]});
        check_eq("wb_data", bus.rf_wdata_o, e[31:0]);
      end
    end
  end

  // Stand-in register file fed by the write port
  always @(posedge clk_i) begin
    if (bus.rf_we_o === 1'b1) rf_mem[bus.rf_waddr_o] <= bus.rf_wdata_o;
  end

  // One cycle: drive inputs, check ready against the model, advance past the edge
  task automatic drive_cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                             input logic se, input logic [4:0] sa);
    bus.req0_valid_i = v0; bus.req0_addr_i = a0; bus.req0_data_i = d0;
    bus.req1_valid_i = v1; bus.req1_addr_i = a1; bus.req1_data_i = d1;
    bus.set_en_i = se; bus.set_addr_i = sa;
    #1;
    g0_m = rst_ni && v0 && (!v1 || rr_m == 1'b0);
    g1_m = rst_ni && v1 && (!v0 || rr_m == 1'b1);
    check_eq("ready0", {31'd0, bus.req0_ready_o}, {31'd0, g0_m});
    check_eq("ready1", {31'd0, bus.req1_ready_o}, {31'd0, g1_m});
    if (!rst_ni) begin
      rr_m = 1'b0;
    end else if (g0_m) begin
      if (a0 != 5'd0) begin exp_q.push_back({a0, d0}); push_cnt++; end
      rr_m = 1'b1;
    end else if (g1_m) begin
      if (a1 != 5'd0) begin exp_q.push_back({a1, d1}); push_cnt++; end
      rr_m = 1'b0;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  logic        p0, p1;
  logic [4:0]  ra0, ra1;
  logic [31:0] rd0, rd1;

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
    rr_m = 1'b0;
    rst_ni = 1'b0;
    bus.set_en_i = 1'b0; bus.set_addr_i = 5'd0;
    bus.r1_addr_i = 5'd5; bus.r2_addr_i = 5'd0;
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd1; bus.req0_data_i = 32'd1;
    bus.req1_valid_i = 1'b1; bus.req1_addr_i = 5'd2; bus.req1_data_i = 32'd2;
    #1;
    check_eq("rst_ready0", {31'd0, bus.req0_ready_o}, 32'd0);
    check_eq("rst_ready1", {31'd0, bus.req1_ready_o}, 32'd0);
    @(posedge clk_i); #1;
    check_eq("rst_we",    {31'd0, bus.rf_we_o}, 32'd0);
    check_eq("rst_waddr", {27'd0, bus.rf_waddr_o}, 32'd0);
    check_eq("rst_wdata", bus.rf_wdata_o, 32'd0);
    check_eq("rst_idle",  {31'd0, bus.idle_o}, 32'd1);
    check_eq("rst_busy",  {31'd0, bus.r1_busy_o}, 32'd0);
    rst_ni = 1'b1;

    // Single request with scoreboard tracking on x5
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    check_eq("t1_busy_set", {31'd0, bus.r1_busy_o}, 32'd1);
    drive_cycle(1'b1, 5'd5, 32'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_eq("t1_we",       {31'd0, bus.rf_we_o}, 32'd1);
    check_eq("t1_busy_hold", {31'd0, bus.r1_busy_o}, 32'd1);
    idle_cycle();
    check_eq("t1_busy_clr", {31'd0, bus.r1_busy_o}, 32'd0);
    check_eq("t1_we_off",   {31'd0, bus.rf_we_o}, 32'd0);
    check_eq("t1_idle",     {31'd0, bus.idle_o}, 32'd1);

    // Bring rr back to 0 with a lone req1 transfer
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
    idle_cycle();

    // Contention: req0 first, req1 held and accepted next, continuous we
    drive_cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0);
    check_eq("c_we0",    {31'd0, bus.rf_we_o}, 32'd1);
    check_eq("c_waddr0", {27'd0, bus.rf_waddr_o}, 32'd3);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0);
    check_eq("c_we1",    {31'd0, bus.rf_we_o}, 32'd1);
    check_eq("c_waddr1", {27'd0, bus.rf_waddr_o}, 32'd4);
    drive_cycle(1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, 1'b0, 5'd0);
    check_eq("c_again_addr", {27'd0, bus.rf_waddr_o}, 32'd10);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'h11, 1'b0, 5'd0);
    idle_cycle();

    // x0 discard, also with set_en on x0
    bus.r1_addr_i = 5'd0;
    drive_cycle(1'b1, 5'd0, 32'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    check_eq("x0_we",   {31'd0, bus.rf_we_o}, 32'd0);
    check_eq("x0_busy", {31'd0, bus.r1_busy_o}, 32'd0);
    check_eq("x0_idle", {31'd0, bus.idle_o}, 32'd1);

    // Same-edge set and clear on x9: set wins
    bus.r1_addr_i = 5'd9;
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    drive_cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_eq("s_we", {31'd0, bus.rf_we_o}, 32'd1);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    check_eq("s_busy9", {31'd0, bus.r1_busy_o}, 32'd1);
    check_eq("s_idle",  {31'd0, bus.idle_o}, 32'd0);

    // Reset while a write sits on the output stage
    drive_cycle(1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    check_eq("r_we_before", {31'd0, bus.rf_we_o}, 32'd1);
    rst_ni = 1'b0;
    idle_cycle();
    rst_ni = 1'b1;
    check_eq("r_we",    {31'd0, bus.rf_we_o}, 32'd0);
    check_eq("r_busy9", {31'd0, bus.r1_busy_o}, 32'd0);
    check_eq("r_idle",  {31'd0, bus.idle_o}, 32'd1);
    idle_cycle();
    check_eq("r_idle2", {31'd0, bus.idle_o}, 32'd1);

    // Random traffic: each requester holds its request until granted
    p0 = 1'b0; p1 = 1'b0;
    ra0 = 5'd0; ra1 = 5'd0; rd0 = 32'd0; rd1 = 32'd0;
    for (int n = 0; n < 80; n++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; ra0 = 5'($urandom_range(0, 31)); rd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; ra1 = 5'($urandom_range(0, 31)); rd1 = $urandom;
      end
      drive_cycle(p0, ra0, rd0, p1, ra1, rd1, 1'b0, 5'd0);
      if (g0_m) p0 = 1'b0;
      if (g1_m) p1 = 1'b0;
    end
    idle_cycle();
    idle_cycle();

    check_eq("drain_q",   exp_q.size(), 32'd0);
    check_eq("pulse_cnt", pulse_cnt, push_cnt);
    check_eq("x0_read",   rf_mem[0], 32'd0);
    check_eq("end_idle",  {31'd0, bus.idle_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
